// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative HI/LO multiply/divide sequencer; define MULDIV_EARLY_OUT_EN for multiply early-out
module muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic [1:0]       OpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic             Abort,
  input  logic             HiLoReadD,
  input  logic             MtHiW,
  input  logic             MtLoW,
  input  logic [WIDTH-1:0] WriteDataW,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic             StallMD
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, next_state;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, mcand, res_mul;
  logic [WIDTH-1:0] opb, abs_a, abs_b, fix_hi, fix_lo;
  logic [WIDTH:0] shifted, diff;
  logic sgn_a, sgn_b, neg_res, neg_rem, is_div, last, early, fits, accept;
  always_comb begin
    sgn_a = ~OpE[0] & SrcAE[WIDTH-1];
    sgn_b = ~OpE[0] & SrcBE[WIDTH-1];
    abs_a = sgn_a ? -SrcAE : SrcAE;
    abs_b = sgn_b ? -SrcBE : SrcBE;
    accept = state == IDLE && StartE && !Abort;
    last = cnt == CW'(WIDTH - 1);
`ifdef MULDIV_EARLY_OUT_EN
    early = state == MUL && cnt != '0 && opb == '0;
`else
    early = 1'b0;
`endif
    shifted = acc[2*WIDTH-1:WIDTH-1];
    diff = shifted - {1'b0, opb};
    fits = shifted >= {1'b0, opb};
    res_mul = neg_res ? -acc : acc;
    fix_lo = is_div ? (DivZero ? '1 : neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]) : res_mul[WIDTH-1:0];
    fix_hi = is_div ? (neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH]) : res_mul[2*WIDTH-1:WIDTH];
    next_state = state != IDLE && Abort ? IDLE :
                 state == IDLE ? (accept ? (OpE[1] ? DIV : MUL) : IDLE) :
                 state == FIX ? IDLE :
                 early || last ? FIX : state;
    Busy = state != IDLE;
    StallMD = HiLoReadD & (Busy | (StartE & ~Abort));
  end
  always_ff @(posedge clk) state <= reset ? IDLE : next_state;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      opb <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      is_div <= 1'b0;
      Hi <= '0;
      Lo <= '0;
      Done <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      Done <= state == FIX && !Abort;
      if (accept) begin
        acc <= OpE[1] ? {{WIDTH{1'b0}}, abs_a} : '0;
        mcand <= {{WIDTH{1'b0}}, abs_a};
        opb <= abs_b;
        cnt <= '0;
        neg_res <= sgn_a ^ sgn_b;
        neg_rem <= sgn_a;
        is_div <= OpE[1];
        DivZero <= OpE[1] && SrcBE == '0;
      end
      if (state == MUL && !early) begin
        acc <= acc + (opb[0] ? mcand : '0);
        mcand <= mcand << 1;
        opb <= opb >> 1;
        cnt <= cnt + CW'(1);
      end
      if (state == DIV) begin
        acc <= {fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0], acc[WIDTH-2:0], fits};
        cnt <= cnt + CW'(1);
      end
      if (state == FIX && !Abort) begin
        Hi <= fix_hi;
        Lo <= fix_lo;
      end else begin
        if (MtHiW) Hi <= WriteDataW;
        if (MtLoW) Lo <= WriteDataW;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed table and corner sequences for muldiv_ctrl
module tb_muldiv_ctrl;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
  localparam int K_FIX = 4;
`else
  localparam bit EARLY = 1'b0;
  localparam int K_FIX = 32;
`endif
  logic clk = 1'b0, reset = 1'b1, StartE = 1'b0, Abort = 1'b0, HiLoReadD = 1'b0, MtHiW = 1'b0, MtLoW = 1'b0;
  logic [1:0] OpE = 2'b00;
  logic [31:0] SrcAE = '0, SrcBE = '0, WriteDataW = '0, Hi, Lo;
  logic Busy, Done, DivZero, StallMD;
  int checks = 0, failures = 0;
  typedef struct {
    logic [1:0] op;
    logic [31:0] a, b, hi, lo;
    logic dz;
    int lat_n, lat_e;
  } vec_t;
  vec_t tbl[11];
  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .StartE(StartE), .OpE(OpE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .Abort(Abort), .HiLoReadD(HiLoReadD), .MtHiW(MtHiW), .MtLoW(MtLoW), .WriteDataW(WriteDataW),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done), .DivZero(DivZero), .StallMD(StallMD)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic do_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    StartE = 1'b1;
    OpE = op;
    SrcAE = a;
    SrcBE = b;
    @(negedge clk);
    StartE = 1'b0;
  endtask
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!Done && lat < 100) begin
      busy_n += int'(Busy);
      @(negedge clk);
      lat++;
    end
    chk("done_seen", {31'd0, Done}, 32'd1);
  endtask
  initial begin
    int lat, busy_n, dcnt;
    tbl[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 33};
    tbl[1]  = '{2'b00, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, 33, 5};
    tbl[2]  = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 33};
    tbl[3]  = '{2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 33, 33};
    tbl[4]  = '{2'b01, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 33, 5};
    tbl[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 33, 33};
    tbl[6]  = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33, 33};
    tbl[7]  = '{2'b00, 32'h80000000, 32'd2,        32'hFFFFFFFF, 32'h00000000, 1'b0, 33, 4};
    tbl[8]  = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33, 33};
    tbl[9]  = '{2'b10, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 33, 33};
    tbl[10] = '{2'b01, 32'h1234,     32'd1,        32'd0,        32'h1234,     1'b0, 33, 3};
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_hi", Hi, 0);
    chk("rst_lo", Lo, 0);
    chk("rst_busy", {31'd0, Busy}, 0);
    chk("rst_done", {31'd0, Done}, 0);
    chk("rst_dz", {31'd0, DivZero}, 0);
    chk("rst_stall", {31'd0, StallMD}, 0);
    MtLoW = 1'b1;
    WriteDataW = 32'h12345678;
    @(negedge clk);
    MtLoW = 1'b0;
    chk("mtlo", Lo, 32'h12345678);
    chk("mtlo_hi_kept", Hi, 0);
    for (int i = 0; i < 11; i++) begin
      do_start(tbl[i].op, tbl[i].a, tbl[i].b);
      chk($sformatf("v%0d_dz_early", i), {31'd0, DivZero}, {31'd0, tbl[i].dz});
      wait_done(lat, busy_n);
      chk($sformatf("v%0d_hi", i), Hi, tbl[i].hi);
      chk($sformatf("v%0d_lo", i), Lo, tbl[i].lo);
      chk($sformatf("v%0d_dz", i), {31'd0, DivZero}, {31'd0, tbl[i].dz});
      chk($sformatf("v%0d_lat", i), lat, EARLY ? tbl[i].lat_e : tbl[i].lat_n);
      chk($sformatf("v%0d_busy", i), busy_n, EARLY ? tbl[i].lat_e : tbl[i].lat_n);
      @(negedge clk);
      chk($sformatf("v%0d_done_once", i), {31'd0, Done}, 0);
    end
    @(negedge clk);
    StartE = 1'b1;
    HiLoReadD = 1'b1;
    OpE = 2'b01;
    SrcAE = 32'hFFFFFFFF;
    SrcBE = 32'hFFFFFFFF;
    #1 chk("stall_first", {31'd0, StallMD}, 1);
    @(negedge clk);
    StartE = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall_busy", {31'd0, StallMD}, 1);
    StartE = 1'b1;
    OpE = 2'b11;
    SrcAE = 32'd1;
    SrcBE = 32'd1;
    @(negedge clk);
    StartE = 1'b0;
    wait_done(lat, busy_n);
    chk("ign_lat", lat + 6, 33);
    chk("ign_hi", Hi, 32'hFFFFFFFE);
    chk("ign_lo", Lo, 32'h00000001);
    chk("stall_done", {31'd0, StallMD}, 0);
    HiLoReadD = 1'b0;
    @(negedge clk);
    MtHiW = 1'b1;
    MtLoW = 1'b1;
    WriteDataW = 32'hCAFEF00D;
    @(negedge clk);
    MtHiW = 1'b0;
    MtLoW = 1'b0;
    do_start(2'b01, 32'd3, 32'hFFFFFFFF);
    repeat (10) @(negedge clk);
    Abort = 1'b1;
    @(negedge clk);
    Abort = 1'b0;
    chk("abort_busy", {31'd0, Busy}, 0);
    dcnt = 0;
    repeat (40) begin
      dcnt += int'(Done);
      @(negedge clk);
    end
    chk("abort_nodone", dcnt, 0);
    chk("abort_hi", Hi, 32'hCAFEF00D);
    chk("abort_lo", Lo, 32'hCAFEF00D);
    StartE = 1'b1;
    Abort = 1'b1;
    HiLoReadD = 1'b1;
    OpE = 2'b01;
    #1 chk("abort_start_stall", {31'd0, StallMD}, 0);
    @(negedge clk);
    StartE = 1'b0;
    Abort = 1'b0;
    HiLoReadD = 1'b0;
    chk("abort_start_busy", {31'd0, Busy}, 0);
    do_start(2'b01, 32'd3, 32'd5);
    repeat (K_FIX) @(negedge clk);
    MtHiW = 1'b1;
    WriteDataW = 32'hDEADBEEF;
    @(negedge clk);
    MtHiW = 1'b0;
    chk("fix_done", {31'd0, Done}, 1);
    chk("fix_hi_wins", Hi, 0);
    chk("fix_lo", Lo, 32'd15);
    do_start(2'b11, 32'd9, 32'd0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", {31'd0, Busy}, 0);
    chk("midrst_hi", Hi, 0);
    chk("midrst_dz", {31'd0, DivZero}, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
